// File: rtl/sort_batch_ctrl.sv
// Batch controller for an external parallel sorter: gathers up to SIZE elements,
// pads short batches, waits out the sorter latency, then streams the sorted batch.
module sort_batch_ctrl #(
  parameter int VALUE_BITS   = 8,
  parameter int DEPTH        = 2,
  parameter int DIRECTION    = 0,
  parameter int SORT_LATENCY = 1,
  localparam int SIZE        = 1 << DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [VALUE_BITS-1:0]      in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [VALUE_BITS-1:0]      out_data,
  output logic                       out_last,
  output logic [SIZE*VALUE_BITS-1:0] srt_in,
  input  logic [SIZE*VALUE_BITS-1:0] srt_out
);

  localparam int CW = DEPTH + 1;
  localparam int WW = $clog2(SORT_LATENCY + 1) + 1;
  localparam logic [VALUE_BITS-1:0] PAD = (DIRECTION == 0) ? '1 : '0;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(SIZE - 1);
  localparam logic [WW-1:0] WAIT_ONE = WW'(1);
  localparam logic [WW-1:0] WAIT_DONE = WW'(SORT_LATENCY);

  typedef enum logic {FILL, SORT} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         n_fill;
  logic [CW-1:0]         n_out;
  logic [CW-1:0]         idx;
  logic [WW-1:0]         wcnt;
  logic                  drain;
  logic [VALUE_BITS-1:0] ibuf [SIZE];
  logic [VALUE_BITS-1:0] obuf [SIZE];

  logic in_xfer;
  logic fill_done;
  logic out_xfer;
  logic last_xfer;
  logic capture;

  assign in_ready  = (state == FILL);
  assign in_xfer   = in_valid && in_ready;
  assign fill_done = in_xfer && (in_last || cnt == LAST_SLOT);

  assign out_valid = drain;
  assign out_data  = obuf[idx[DEPTH-1:0]];
  assign out_last  = drain && (idx == n_out - ONE);
  assign out_xfer  = out_valid && out_ready;
  assign last_xfer = out_xfer && out_last;

  // The output buffer may be reloaded on the very edge its final element leaves.
  assign capture = (state == SORT) && (wcnt == WAIT_DONE) && (!drain || last_xfer);

  always_comb begin
    srt_in = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      srt_in[i*VALUE_BITS +: VALUE_BITS] = ibuf[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= FILL;
      cnt    <= '0;
      n_fill <= '0;
      n_out  <= '0;
      idx    <= '0;
      wcnt   <= '0;
      drain  <= 1'b0;
      for (int unsigned i = 0; i < SIZE; i++) begin
        ibuf[i] <= PAD;
        obuf[i] <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          if (in_xfer) begin
            ibuf[cnt[DEPTH-1:0]] <= in_data;
            cnt <= cnt + ONE;
            if (fill_done) begin
              for (int unsigned i = 0; i < SIZE; i++) begin
                if (i > 32'(cnt)) ibuf[i] <= PAD;
              end
              n_fill <= cnt + ONE;
              wcnt   <= '0;
              state  <= SORT;
            end
          end
        end
        SORT: begin
          if (wcnt != WAIT_DONE) begin
            wcnt <= wcnt + WAIT_ONE;
          end else if (capture) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
              obuf[i] <= srt_out[i*VALUE_BITS +: VALUE_BITS];
            end
            n_out <= n_fill;
            cnt   <= '0;
            state <= FILL;
          end
        end
      endcase

      if (capture) begin
        drain <= 1'b1;
        idx   <= '0;
      end else if (out_xfer) begin
        idx <= idx + ONE;
        if (out_last) drain <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sort_batch_ctrl.sv
// Bench for sort_batch_ctrl: ascending and descending instances share stimulus;
// a batch-level reference model feeds per-instance scoreboards.
module tb_sort_batch_ctrl;

  localparam int W     = 8;
  localparam int DEPTH = 2;
  localparam int SIZE  = 1 << DEPTH;
  localparam int LAT   = 1;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  logic in_ready0, in_ready1, ov0, ov1, ol0, ol1;
  logic [W-1:0] od0, od1;
  logic [SIZE*W-1:0] si0, si1, so0, so1;
  logic [SIZE*W-1:0] p0 [LAT];
  logic [SIZE*W-1:0] p1 [LAT];

  int checks = 0;
  int errors = 0;
  int xfer0 = 0;
  int ready_mode = 1;

  exp_t exp0[$];
  exp_t exp1[$];
  logic [W-1:0] cur[$];

  always #5 clk = ~clk;

  sort_batch_ctrl #(.VALUE_BITS(W), .DEPTH(DEPTH), .DIRECTION(0), .SORT_LATENCY(LAT)) u_asc (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_last(ol0),
    .srt_in(si0), .srt_out(so0)
  );

  sort_batch_ctrl #(.VALUE_BITS(W), .DEPTH(DEPTH), .DIRECTION(1), .SORT_LATENCY(LAT)) u_desc (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_last(ol1),
    .srt_in(si1), .srt_out(so1)
  );

  // Behavioural sorter with LAT register stages.
  function automatic logic [SIZE*W-1:0] sortv(input logic [SIZE*W-1:0] v, input bit desc);
    logic [W-1:0] q[$];
    logic [SIZE*W-1:0] r;
    r = '0;
    for (int i = 0; i < SIZE; i++) q.push_back(v[i*W +: W]);
    if (desc) q.rsort(); else q.sort();
    for (int i = 0; i < SIZE; i++) r[i*W +: W] = q[i];
    return r;
  endfunction

  always @(posedge clk) begin
    p0[0] <= sortv(si0, 1'b0);
    p1[0] <= sortv(si1, 1'b1);
    for (int i = 1; i < LAT; i++) begin
      p0[i] <= p0[i-1];
      p1[i] <= p1[i-1];
    end
  end
  assign so0 = p0[LAT-1];
  assign so1 = p1[LAT-1];

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic score(input int ch, input logic [W-1:0] d, input logic l);
    exp_t e;
    checks++;
    if ((ch == 0 && exp0.size() == 0) || (ch == 1 && exp1.size() == 0)) begin
      errors++;
      $display("FAIL out%0d unexpected: got data=%0d last=%0b, required no output", ch, d, l);
    end else begin
      e = (ch == 0) ? exp0.pop_front() : exp1.pop_front();
      if (d !== e.d || l !== e.l) begin
        errors++;
        $display("FAIL out%0d: got data=%0d last=%0b, required data=%0d last=%0b", ch, d, l, e.d, e.l);
      end
    end
  endtask

  logic hold_v = 1'b0;
  logic [W-1:0] hold_d = '0;
  logic hold_l = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && ov0) begin
        checks++;
        if (od0 !== hold_d || ol0 !== hold_l) begin
          errors++;
          $display("FAIL hold: got data=%0d last=%0b, required %0d/%0b", od0, ol0, hold_d, hold_l);
        end
      end
      hold_v = ov0 && !out_ready;
      hold_d = od0;
      hold_l = ol0;
      if (ov0 && out_ready) begin
        xfer0++;
        score(0, od0, ol0);
      end
      if (ov1 && out_ready) score(1, od1, ol1);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Reference model: a batch closes at SIZE elements or on last; it emerges sorted.
  task automatic model_accept(input logic [W-1:0] d, input logic l);
    cur.push_back(d);
    if (l || cur.size() == SIZE) begin
      logic [W-1:0] a[$];
      a = cur;
      a.sort();
      foreach (a[i]) exp0.push_back(exp_t'{d: a[i], l: (i == a.size() - 1)});
      a.rsort();
      foreach (a[i]) exp1.push_back(exp_t'{d: a[i], l: (i == a.size() - 1)});
      cur.delete();
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [W-1:0] d, input logic l);
    int unsigned g;
    g = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready0 && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    checks++;
    if (!in_ready0) begin
      errors++;
      $display("FAIL push timeout: in_ready=0 after %0d cycles, required 1", g);
    end else begin
      model_accept(d, l);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned g;
    g = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && g < 1000) begin
      @(posedge clk);
      #1;
      g++;
    end
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL drain timeout: pending %0d/%0d, required 0/0", exp0.size(), exp1.size());
    end
    idle(2);
  endtask

  initial begin
    int base;
    int unsigned g;

    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    chk("reset in_ready", 32'(in_ready0), 1);
    chk("reset out_valid", 32'(ov0), 0);
    chk("reset out_last", 32'(ol0), 0);
    chk("reset out_valid desc", 32'(ov1), 0);

    // Full batch, latency of the first sorted element.
    ready_mode = 1;
    out_ready  = 1'b1;
    push(8'd7, 1'b0); push(8'd3, 1'b0); push(8'd9, 1'b0); push(8'd1, 1'b0);
    chk("sort in_ready", 32'(in_ready0), 0);
    chk("latency +0", 32'(ov0), 0);
    idle(1);
    chk("latency +1", 32'(ov0), 0);
    idle(1);
    chk("latency +2", 32'(ov0), 1);
    wait_drain();

    // Partial batch flushed by last.
    base = xfer0;
    push(8'd5, 1'b0); push(8'd2, 1'b1);
    wait_drain();
    idle(4);
    chk("partial transfer count", 32'(xfer0 - base), 2);

    // Values equal to the pad, then a single-element batch.
    push(8'd255, 1'b0); push(8'd0, 1'b0); push(8'd255, 1'b0); push(8'd0, 1'b0);
    push(8'd255, 1'b1);
    wait_drain();

    // Backpressure: second batch fills and then stalls in SORT.
    ready_mode = 0;
    out_ready  = 1'b0;
    push(8'd4, 1'b0); push(8'd3, 1'b0); push(8'd2, 1'b0); push(8'd1, 1'b0);
    push(8'd8, 1'b0); push(8'd7, 1'b0); push(8'd6, 1'b0); push(8'd5, 1'b0);
    idle(3);
    chk("stall in_ready", 32'(in_ready0), 0);
    chk("stall out_valid", 32'(ov0), 1);
    chk("stall out_data", 32'(od0), 1);
    chk("stall out_data desc", 32'(od1), 4);
    ready_mode = 1;
    wait_drain();

    // Reset after the second output transfer discards the rest of the batch.
    base = xfer0;
    push(8'd7, 1'b0); push(8'd3, 1'b0); push(8'd9, 1'b0); push(8'd1, 1'b0);
    g = 0;
    while (xfer0 < base + 2 && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("two transfers before reset", 32'(xfer0 - base), 2);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    exp0.delete();
    exp1.delete();
    cur.delete();
    chk("post-reset out_valid", 32'(ov0), 0);
    chk("post-reset out_valid desc", 32'(ov1), 0);
    chk("post-reset in_ready", 32'(in_ready0), 1);
    chk("post-reset out_last", 32'(ol0), 0);
    idle(5);
    chk("post-reset quiet", 32'(ov0), 0);

    // Short batch, both directions.
    push(8'd7, 1'b0); push(8'd3, 1'b0); push(8'd9, 1'b1);
    wait_drain();

    // Full batch with last on its final element.
    push(8'd10, 1'b0); push(8'd40, 1'b0); push(8'd20, 1'b0); push(8'd30, 1'b1);
    push(8'd6, 1'b1);
    wait_drain();

    // Randomised traffic with random backpressure and input gaps.
    ready_mode = 2;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      push(W'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0));
    end
    if (cur.size() != 0) push(W'($urandom_range(0, 255)), 1'b1);
    ready_mode = 1;
    wait_drain();
    idle(6);
    chk("final pending asc", 32'(exp0.size()), 0);
    chk("final out_valid", 32'(ov0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sort_batch_ctrl.md
SORT_BATCH_CTRL -- requirements
Module: sort_batch_ctrl

Interface
REQ-001 SHALL have parameter VALUE_BITS, default 8: element width in bits.
REQ-002 SHALL have parameter DEPTH, default 2: log2 of the batch size; SIZE = 1 << DEPTH is derived and SHALL NOT be overridden.
REQ-003 SHALL have parameter DIRECTION, default 0: 0 = ascending output, 1 = descending; SHALL match the attached sorter.
REQ-004 SHALL have parameter SORT_LATENCY, default 1: register stages in the attached sorter.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 in_valid  in  1  input element valid.
REQ-008 in_ready  out  1  controller accepts an input element.
REQ-009 in_data  in  VALUE_BITS  input element.
REQ-010 in_last  in  1  final element of a batch; flushes a partial batch.
REQ-011 out_valid  out  1  sorted element valid.
REQ-012 out_ready  in  1  downstream accepts an element.
REQ-013 out_data  out  VALUE_BITS  sorted element.
REQ-014 out_last  out  1  final real element of the batch.
REQ-015 srt_in  out  SIZE x VALUE_BITS  packed vector driven to the sorter input; element 0 in the LSBs.
REQ-016 srt_out  in  SIZE x VALUE_BITS  packed vector returned from the sorter output.

Function
REQ-017 A transfer SHALL occur on any edge where valid and ready are both high; data SHALL be sampled only on transfers.
REQ-018 The fill side SHALL have states FILL and SORT; the drain side SHALL have a DRAIN flag and a separate output buffer.
REQ-019 In FILL, in_ready SHALL be 1 and accepted elements SHALL be written to input-buffer slot cnt; cnt increments by 1 per accepted element.
REQ-020 FILL -> SORT SHALL occur on the edge that accepts element SIZE-1 or accepts any element with in_last=1.
REQ-021 On that edge, slots cnt+1..SIZE-1 SHALL be loaded with pad: all-ones for DIRECTION=0, all-zeros for DIRECTION=1, so that pad values sort to the tail; batch length n = cnt+1 SHALL be latched.
REQ-022 srt_in SHALL equal the input buffer at all times and SHALL NOT change while in SORT.
REQ-023 SORT SHALL last at least SORT_LATENCY+1 cycles (wait counter); srt_out SHALL be captured into the output buffer on the edge ending the last of these cycles, and only if DRAIN=0.
REQ-024 If DRAIN=1 when the wait completes, the controller SHALL remain in SORT with srt_in stable and capture on the first edge with DRAIN=0, including the edge on which the last element drains.
REQ-025 On the capture edge: DRAIN := 1, output index := 0, fill side -> FILL with cnt := 0; in_ready SHALL be 0 throughout SORT.
REQ-026 In DRAIN: out_valid=1, out_data = output buffer[index], out_last = (index == n-1); the index advances on each output transfer.
REQ-027 The output transfer with out_last=1 SHALL clear DRAIN; pad slots SHALL never be emitted.
REQ-028 out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 Filling of the next batch SHALL proceed concurrently with DRAIN.
REQ-030 in_last asserted on a full batch (element SIZE-1) SHALL behave as a plain full batch, with no extra empty batch.
REQ-031 Counters SHALL be DEPTH+1 bits wide; no wrap-around may occur within a batch.

Reset
REQ-032 While rst_n=0 at an edge: state := FILL, cnt := 0, DRAIN := 0, wait counter := 0, input buffer := pad; next cycle in_ready=1, out_valid=0, out_last=0.
REQ-033 Reset SHALL discard any partially filled, sorting or draining batch; no element of it SHALL appear afterwards.

Verification (SIZE=4, VALUE_BITS=8, DIRECTION=0, SORT_LATENCY=1 unless stated)
REQ-034 Input 7,3,9,1 back-to-back, out_ready=1 -> in_ready=0 after the 4th beat; out_valid rises 2 cycles after the accepting edge; output 1,3,7,9 with out_last on 9.
REQ-035 Input 5,2 with in_last on 2 -> output 2,5 with out_last on 5; exactly 2 output transfers.
REQ-036 Input 255,0,255,0 -> output 0,0,255,255; followed by a partial batch 255 (last) -> single output 255 with out_last=1.
REQ-037 Batch A = 4,3,2,1 then batch B = 8,7,6,5 with out_ready=0 for 10 cycles -> out_data holds 1; B fills, then SORT holds with in_ready=0; after release, output is 1,2,3,4,5,6,7,8 with no loss.
REQ-038 rst_n=0 for 1 cycle after the 2nd output transfer of batch 7,3,9,1 -> out_valid=0 next cycle, in_ready=1, and 7,9 are never emitted.
REQ-039 DIRECTION=1: input 7,3,9 with last on 9 -> output 9,7,3 with out_last on 3.
